// File: rtl/updn_counter.sv
`default_nettype none
// ============================================================================
//  Module      : updn_counter
//  Description : Loadable up/down counter with terminal count and a
//                registered carry/borrow pulse. Define UPDN_COUNTER_SAT_EN
//                to saturate at the limits instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module updn_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             co
);

    localparam logic [WIDTH-1:0] c_ONES = '1;
    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic             r_co;
    logic             w_tc;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_next;

    // Terminal count looks at the live direction so a same-edge direction
    // change affects both the step and the carry decision.
    assign w_tc   = up ? (r_q == c_ONES) : (r_q == c_ZERO);
    assign w_step = up ? (r_q + c_ONE) : (r_q - c_ONE);

`ifdef UPDN_COUNTER_SAT_EN
    assign w_next = w_tc ? r_q : w_step;
`else
    assign w_next = w_step;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_q  <= c_ZERO;
            r_co <= 1'b0;
        end else if (ld) begin
            r_q  <= d;
            r_co <= 1'b0;
        end else if (en) begin
            r_q  <= w_next;
            r_co <= w_tc;
        end else begin
            r_co <= 1'b0;
        end
    end

    assign q  = r_q;
    assign qb = ~r_q;
    assign tc = w_tc;
    assign co = r_co;

endmodule
`default_nettype wire
